// File: rtl/tmg_mac_accum_if.sv
// ============================================================================
// Module      : tmg_mac_accum_if
// Description : Weight-load, run-control, pixel-stream and result bundle for
//               the Toeplitz MAC accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tmg_mac_accum_if #(
    parameter int DW = 8,
    parameter int IW = 4,
    parameter int AW = 20
) ();
    logic          w_we;
    logic [IW-1:0] w_idx;
    logic [7:0]    w_data;
    logic          start;
    logic [7:0]    num_win;
    logic [DW-1:0] din;
    logic          din_valid;
    logic [AW-1:0] result;
    logic          res_valid;
    logic          done;
    logic          busy;
    logic [7:0]    win_cnt;

    modport master (
        output w_we, w_idx, w_data, start, num_win, din, din_valid,
        input  result, res_valid, done, busy, win_cnt
    );

    modport slave (
        input  w_we, w_idx, w_data, start, num_win, din, din_valid,
        output result, res_valid, done, busy, win_cnt
    );
endinterface

`default_nettype wire

// File: rtl/tmg_mac_accum.sv
// ============================================================================
// Module      : tmg_mac_accum
// Description : Multiply-accumulate of a Toeplitz-ordered pixel stream against
//               KLEN signed kernel taps; one result per window, num_win windows
//               per run. Define TMG_MAC_RELU_EN to clamp negative sums to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmg_mac_accum #(
    parameter int DW   = 8,
    parameter int KLEN = 9,
    parameter int AW   = 20,
    parameter int IW   = 4
) (
    input  wire            clk,
    input  wire            rst,
    tmg_mac_accum_if.slave bus
);

    localparam int            c_PW       = DW + 9;
    localparam logic [IW-1:0] c_LAST_TAP = IW'(KLEN - 1);
    localparam logic [IW:0]   c_KLEN_X   = (IW + 1)'(KLEN);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t        state_q;
    logic          busy_q;
    logic          res_valid_q;
    logic          done_q;
    logic [AW-1:0] result_q;
    logic [AW-1:0] acc_q;
    logic [IW-1:0] tap_q;
    logic [7:0]    win_cnt_q;
    logic [7:0]    num_win_q;
    logic [7:0]    weight_q [KLEN];

    logic signed [c_PW-1:0] w_din_ext;
    logic signed [c_PW-1:0] w_wt_ext;
    logic signed [c_PW-1:0] w_prod;
    logic        [AW-1:0]   w_prod_ext;
    logic        [AW-1:0]   w_sum_d;
    logic        [AW-1:0]   w_res_d;
    logic        [7:0]      w_win_cnt_d;
    logic                   w_idx_ok;

    // Pixel is unsigned, weight is signed: both widened to the product width.
    assign w_din_ext = {{9{1'b0}}, bus.din};
    assign w_wt_ext  = {{(DW + 1){weight_q[tap_q][7]}}, weight_q[tap_q]};
    assign w_prod    = w_din_ext * w_wt_ext;

    generate
        if (AW > c_PW) begin : g_prod_sext
            assign w_prod_ext = {{(AW - c_PW){w_prod[c_PW-1]}}, w_prod};
        end else if (AW == c_PW) begin : g_prod_same
            assign w_prod_ext = w_prod;
        end else begin : g_prod_trunc
            assign w_prod_ext = w_prod[AW-1:0];
        end
    endgenerate

    assign w_sum_d     = acc_q + w_prod_ext;
    assign w_win_cnt_d = win_cnt_q + 8'd1;
    assign w_idx_ok    = ({1'b0, bus.w_idx} < c_KLEN_X);

`ifdef TMG_MAC_RELU_EN
    assign w_res_d = w_sum_d[AW-1] ? '0 : w_sum_d;
`else
    assign w_res_d = w_sum_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            acc_q       <= '0;
            tap_q       <= '0;
            win_cnt_q   <= '0;
            num_win_q   <= '0;
            for (int i = 0; i < KLEN; i++) begin
                weight_q[i] <= '0;
            end
        end else begin
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.w_we && w_idx_ok) begin
                        weight_q[bus.w_idx] <= bus.w_data;
                    end
                    if (bus.start) begin
                        if (bus.num_win != 8'd0) begin
                            state_q   <= S_ACC;
                            busy_q    <= 1'b1;
                            num_win_q <= bus.num_win;
                            acc_q     <= '0;
                            tap_q     <= '0;
                            win_cnt_q <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_ACC: begin
                    if (bus.din_valid) begin
                        if (tap_q == c_LAST_TAP) begin
                            result_q    <= w_res_d;
                            res_valid_q <= 1'b1;
                            acc_q       <= '0;
                            tap_q       <= '0;
                            win_cnt_q   <= w_win_cnt_d;
                            // Final window of the run: leave ACC with done aligned to res_valid.
                            if (w_win_cnt_d == num_win_q) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            acc_q <= w_sum_d;
                            tap_q <= tap_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result    = result_q;
    assign bus.res_valid = res_valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.win_cnt   = win_cnt_q;

endmodule

`default_nettype wire
